// File: rtl/decod_pkg.sv
// Shared definitions for the timed 2-to-4 decoder: FSM states, code and one-hot constants.
// The one-hot constants are the same ones the 4-to-2 access encoder uses.
package decod_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [1:0] A0 = 2'b00;
   localparam logic [1:0] A1 = 2'b01;
   localparam logic [1:0] A2 = 2'b10;
   localparam logic [1:0] A3 = 2'b11;

   localparam logic [3:0] W0 = 4'b0001;
   localparam logic [3:0] W1 = 4'b0010;
   localparam logic [3:0] W2 = 4'b0100;
   localparam logic [3:0] W3 = 4'b1000;

   // Hold and gap lengths are limited to 255, so an 8-bit counter suffices.
   localparam int unsigned CNT_W = $clog2(256);

endpackage

// File: rtl/decod_2_4_comb.sv
// Pure combinational 2-bit code to one-hot gate line.
module decod_2_4_comb
   import decod_pkg::*;
(
   input  logic [1:0] code,
   output logic [3:0] one_hot
);

   always_comb begin
      one_hot = '0;
      case (code)
         A0: one_hot = W0;
         A1: one_hot = W1;
         A2: one_hot = W2;
         A3: one_hot = W3;
      endcase
   end

endmodule

// File: rtl/decodificador_2_4_temporizado.sv
// Registered 2-to-4 decoder with a timed hold and guard gap, behind a valid/ready handshake.
// Optional sticky overrun flag built only when DECOD_OVERRUN_EN is defined.
module decodificador_2_4_temporizado
   import decod_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 8,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       input_valid,
   input  logic [1:0] input_code,
   output logic       ready,
   output logic [3:0] output_decodificado,
   output logic       busy,
   output logic       done,
   output logic       overrun
);

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       one_hot;
   logic             accept;

   decod_2_4_comb u_decod (
      .code    (input_code),
      .one_hot (one_hot)
   );

   assign accept = input_valid && ready;

   // ready/busy/done are registered alongside the state so no output depends on input_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= IDLE;
         cnt                 <= '0;
         output_decodificado <= '0;
         ready               <= 1'b1;
         busy                <= 1'b0;
         done                <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state               <= HOLD;
                  cnt                 <= HOLD_LOAD;
                  output_decodificado <= one_hot;
                  ready               <= 1'b0;
                  busy                <= 1'b1;
               end
            end
            HOLD: begin
               if (cnt == '0) begin
                  output_decodificado <= '0;
                  done                <= 1'b1;
                  if (GAP_CYCLES > 0) begin
                     state <= GAP;
                     cnt   <= GAP_LOAD;
                  end else begin
                     state <= IDLE;
                     ready <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            GAP: begin
               if (cnt == '0) begin
                  state <= IDLE;
                  ready <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state               <= IDLE;
               cnt                 <= '0;
               output_decodificado <= '0;
               ready               <= 1'b1;
               busy                <= 1'b0;
            end
         endcase
      end
   end

`ifdef DECOD_OVERRUN_EN
   // Dropped requests are remembered until reset; the FSM never looks at this flag.
   always_ff @(posedge clk) begin
      if (reset)
         overrun <= 1'b0;
      else if (input_valid && !ready)
         overrun <= 1'b1;
   end
`else
   assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_decodificador_2_4_temporizado.sv
// Bench for decodificador_2_4_temporizado: two instances (HOLD=8/GAP=2 and HOLD=1/GAP=0)
// checked every cycle against a time-since-accept model plus directed literal checks.
module tb_decodificador_2_4_temporizado;

`ifdef DECOD_OVERRUN_EN
   localparam bit OVR_EN = 1'b1;
`else
   localparam bit OVR_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic [1:0] vld;
   logic [1:0] code [2];
   logic [1:0] rdy_o, busy_o, done_o, ovr_o;
   logic [3:0] out_o [2];

   int n_checks = 0;
   int n_fail   = 0;

   // Model: per instance, edges elapsed since the last accept edge.
   int         hold_len [2] = '{8, 1};
   int         gap_len  [2] = '{2, 0};
   bit         act  [2];
   int         k    [2];
   logic [1:0] mc   [2];
   bit         movr [2];
   bit         model_valid = 1'b0;

   decodificador_2_4_temporizado #(.HOLD_CYCLES(8), .GAP_CYCLES(2)) dut_a (
      .clk                 (clk),
      .reset               (reset),
      .input_valid         (vld[0]),
      .input_code          (code[0]),
      .ready               (rdy_o[0]),
      .output_decodificado (out_o[0]),
      .busy                (busy_o[0]),
      .done                (done_o[0]),
      .overrun             (ovr_o[0])
   );

   decodificador_2_4_temporizado #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut_b (
      .clk                 (clk),
      .reset               (reset),
      .input_valid         (vld[1]),
      .input_code          (code[1]),
      .ready               (rdy_o[1]),
      .output_decodificado (out_o[1]),
      .busy                (busy_o[1]),
      .done                (done_o[1]),
      .overrun             (ovr_o[1])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act_v, exp_v);
      end
   endtask

   function automatic bit m_busy(input int d);
      return act[d] && k[d] >= 1 && k[d] <= hold_len[d] + gap_len[d];
   endfunction

   function automatic logic [3:0] m_out(input int d);
      if (act[d] && k[d] >= 1 && k[d] <= hold_len[d])
         return 4'(1 << mc[d]);
      return 4'b0000;
   endfunction

   function automatic bit m_done(input int d);
      return act[d] && k[d] == hold_len[d] + 1;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (reset) begin
            act[d]  <= 1'b0;
            k[d]    <= 0;
            movr[d] <= 1'b0;
         end else begin
            if (vld[d] && m_busy(d))
               movr[d] <= 1'b1;
            if (vld[d] && !m_busy(d)) begin
               act[d] <= 1'b1;
               k[d]   <= 1;
               mc[d]  <= code[d];
            end else if (act[d] && k[d] < 1000) begin
               k[d] <= k[d] + 1;
            end
         end
      end
      if (reset)
         model_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (model_valid) begin
         for (int d = 0; d < 2; d++) begin
            check($sformatf("model_out[%0d]", d),   out_o[d],  m_out(d));
            check($sformatf("model_ready[%0d]", d), rdy_o[d],  !m_busy(d));
            check($sformatf("model_busy[%0d]", d),  busy_o[d], m_busy(d));
            check($sformatf("model_done[%0d]", d),  done_o[d], m_done(d));
            check($sformatf("model_ovr[%0d]", d),   ovr_o[d],  OVR_EN & movr[d]);
         end
      end
   end

   task automatic wait_ready(input int d);
      int n = 0;
      while (rdy_o[d] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("wait_ready[%0d]", d), rdy_o[d], 1);
   endtask

   initial begin
      int hits;
      reset   = 1'b1;
      vld     = '0;
      code[0] = '0;
      code[1] = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", rdy_o[0], 1);
      check("rst_out",   out_o[0], 4'b0000);
      check("rst_busy",  busy_o[0], 0);
      check("rst_done",  done_o[0], 0);
      check("rst_ovr",   ovr_o[0], 0);
      reset = 1'b0;
      @(negedge clk);

      // Single accept of code 10: 8 hold cycles, done in cycle 9, ready in cycle 11.
      vld[0] = 1'b1; code[0] = 2'b10;
      @(negedge clk);
      vld[0] = 1'b0;
      for (int i = 1; i <= 11; i++) begin
         check("t1_out",   out_o[0],  (i <= 8) ? 4'b0100 : 4'b0000);
         check("t1_done",  done_o[0], (i == 9) ? 1 : 0);
         check("t1_busy",  busy_o[0], (i <= 10) ? 1 : 0);
         check("t1_ready", rdy_o[0],  (i == 11) ? 1 : 0);
         if (i < 11) @(negedge clk);
      end

      // Sweep all four codes; each one-hot appears for exactly 8 cycles.
      for (int c = 0; c < 4; c++) begin
         wait_ready(0);
         vld[0] = 1'b1; code[0] = 2'(c);
         @(negedge clk);
         vld[0] = 1'b0;
         hits = 0;
         for (int i = 1; i <= 10; i++) begin
            if (out_o[0] == 4'(1 << c)) hits++;
            else check("sweep_gap_zero", out_o[0], 4'b0000);
            @(negedge clk);
         end
         check($sformatf("sweep_hold_len_%0d", c), hits, 8);
      end

      // valid held high through HOLD and GAP: no re-accept until ready returns.
      wait_ready(0);
      vld[0] = 1'b1; code[0] = 2'b00;
      @(negedge clk);
      code[0] = 2'b11;
      for (int i = 1; i <= 12; i++) begin
         if (i <= 8)       check("ovr_out_hold", out_o[0], 4'b0001);
         else if (i <= 11) check("ovr_out_gap",  out_o[0], 4'b0000);
         else              check("ovr_next",     out_o[0], 4'b1000);
         if (i >= 2) check("ovr_flag", ovr_o[0], OVR_EN);
         if (i < 12) @(negedge clk);
      end
      vld[0] = 1'b0;

      // Reset in the 4th hold cycle discards the code without a done pulse.
      wait_ready(0);
      vld[0] = 1'b1; code[0] = 2'b01;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_out", out_o[0], 4'b0010);
      reset = 1'b1;
      @(negedge clk);
      check("mrst_out",   out_o[0], 4'b0000);
      check("mrst_ready", rdy_o[0], 1);
      check("mrst_busy",  busy_o[0], 0);
      check("mrst_done",  done_o[0], 0);
      check("mrst_ovr",   ovr_o[0], 0);
      reset = 1'b0;
      @(negedge clk);
      check("mrst_done2", done_o[0], 0);
      check("mrst_out2",  out_o[0], 4'b0000);

      // HOLD=1, GAP=0 with valid held: period-2 pattern, done in every idle cycle.
      vld[1] = 1'b1; code[1] = 2'b01;
      for (int j = 1; j <= 10; j++) begin
         @(negedge clk);
         check("b_out",   out_o[1],  (j % 2 == 1) ? 4'b0010 : 4'b0000);
         check("b_done",  done_o[1], (j % 2 == 0) ? 1 : 0);
         check("b_ready", rdy_o[1],  (j % 2 == 0) ? 1 : 0);
      end
      check("b_ovr", ovr_o[1], OVR_EN);
      vld[1] = 1'b0;
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
